// File: rtl/prbs16_checker.sv
// Self-synchronising checker for the x^16+x^14+x^13+x^11+1 PRBS stream.
// Optional valid-bit counter for BER measurement: define PRBS16_CHK_BITCNT_EN.
module prbs16_checker #(
  parameter int LOCK_MATCHES = 8,
  parameter int WINDOW       = 64,
  parameter int ERR_LIMIT    = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
`ifdef PRBS16_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_count
`endif
);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_VERIFY  = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [7:0]       LOCK_M   = 8'(LOCK_MATCHES);
  localparam logic [15:0]      WIN_LAST = 16'(WINDOW - 1);
  localparam logic [15:0]      ERR_LIM  = 16'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [15:0]        hist_r, hist_s;
  logic [3:0]         fill_r, fill_s;
  logic [7:0]         match_r, match_s;
  logic [15:0]        win_pos_r, win_pos_s;
  logic [15:0]        win_err_r, win_err_s;
  logic [15:0]        win_err_inc_s;
  logic [CNT_W-1:0]   err_cnt_s;
  logic               pred_s;
  logic               err_hit_s;

  // Next-state, history and counter logic
  always_comb begin
    pred_s        = hist_r[15] ^ hist_r[13] ^ hist_r[12] ^ hist_r[10];
    state_s       = state_r;
    hist_s        = hist_r;
    fill_s        = fill_r;
    match_s       = match_r;
    win_pos_s     = win_pos_r;
    win_err_s     = win_err_r;
    err_hit_s     = 1'b0;
    win_err_inc_s = win_err_r;
    if (din_valid) begin
      case (state_r)
        ST_ACQUIRE: begin
          hist_s = {hist_r[14:0], din};
          // 4-bit fill wraps to 0 on the 16th bit either way
          fill_s = fill_r + 4'd1;
          match_s = 8'd0;
          if ((fill_r == 4'd15) && ({hist_r[14:0], din} != 16'd0)) begin
            state_s = ST_VERIFY;
          end else begin
            state_s = ST_ACQUIRE;
          end
        end
        ST_VERIFY: begin
          hist_s = {hist_r[14:0], din};
          if (din == pred_s) begin
            match_s = match_r + 8'd1;
            if ((match_r + 8'd1) == LOCK_M) begin
              state_s   = ST_LOCKED;
              win_pos_s = 16'd0;
              win_err_s = 16'd0;
            end else begin
              state_s = ST_VERIFY;
            end
          end else begin
            state_s = ST_ACQUIRE;
            fill_s  = 4'd0;
            match_s = 8'd0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the prediction, not din, feeds the history
          hist_s        = {hist_r[14:0], pred_s};
          err_hit_s     = din ^ pred_s;
          win_err_inc_s = win_err_r + {15'd0, err_hit_s};
          if (win_err_inc_s == ERR_LIM) begin
            state_s   = ST_ACQUIRE;
            fill_s    = 4'd0;
            match_s   = 8'd0;
            win_pos_s = 16'd0;
            win_err_s = 16'd0;
          end else if (win_pos_r == WIN_LAST) begin
            win_pos_s = 16'd0;
            win_err_s = 16'd0;
          end else begin
            win_pos_s = win_pos_r + 16'd1;
            win_err_s = win_err_inc_s;
          end
        end
        default: begin
          state_s = ST_ACQUIRE;
          fill_s  = 4'd0;
          match_s = 8'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    if (err_clr) begin
      err_cnt_s = err_hit_s ? CNT_ONE : '0;
    end else if (err_hit_s && (err_count != CNT_MAX)) begin
      err_cnt_s = err_count + CNT_ONE;
    end else begin
      err_cnt_s = err_count;
    end
  end

  // State, history and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_ACQUIRE;
      hist_r    <= 16'd0;
      fill_r    <= 4'd0;
      match_r   <= 8'd0;
      win_pos_r <= 16'd0;
      win_err_r <= 16'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state_r   <= state_s;
      hist_r    <= hist_s;
      fill_r    <= fill_s;
      match_r   <= match_s;
      win_pos_r <= win_pos_s;
      win_err_r <= win_err_s;
      locked    <= (state_s == ST_LOCKED);
      err_pulse <= err_hit_s;
      err_count <= err_cnt_s;
    end
  end

`ifdef PRBS16_CHK_BITCNT_EN
  logic [31:0] bit_cnt_s;
  logic        bit_hit_s;

  // Valid bits seen while locked, saturating, cleared with the error count
  always_comb begin
    bit_hit_s = din_valid && (state_r == ST_LOCKED);
    if (err_clr) begin
      bit_cnt_s = {31'd0, bit_hit_s};
    end else if (bit_hit_s && (bit_count != 32'hFFFF_FFFF)) begin
      bit_cnt_s = bit_count + 32'd1;
    end else begin
      bit_cnt_s = bit_count;
    end
  end

  // Bit counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_count <= 32'd0;
    end else begin
      bit_count <= bit_cnt_s;
    end
  end
`endif

endmodule

// File: tb/tb_prbs16_checker.sv
// Scoreboard bench for prbs16_checker: default instance plus a CNT_W=4 instance
// fed with the same stimulus; expected outputs come from a behavioural model.
module tb_prbs16_checker;

  localparam int LM  = 8;
  localparam int WIN = 64;
  localparam int EL  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic        din_valid;
  logic        err_clr;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked4, err_pulse4;
  logic [3:0]  err_count4;
`ifdef PRBS16_CHK_BITCNT_EN
  logic [31:0] bit_count, bit_count4;
`endif

  always #5 clk = ~clk;

  prbs16_checker dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
`ifdef PRBS16_CHK_BITCNT_EN
    , .bit_count(bit_count)
`endif
  );

  prbs16_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .err_clr(err_clr),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
`ifdef PRBS16_CHK_BITCNT_EN
    , .bit_count(bit_count4)
`endif
  );

  typedef struct packed {
    logic        lk;
    logic        pl;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pulses  = 0;
  logic [15:0] gen_r;

  // behavioural model state
  int          m_st, m_fill, m_match, m_wpos, m_werr, m_cnt, m_cnt4;
  logic [15:0] m_h;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
    m_cnt = 0; m_cnt4 = 0; m_h = 16'd0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic d, input logic v, input logic c);
    logic p, e;
    exp_t x;
    e = 1'b0;
    if (v) begin
      p = m_h[15] ^ m_h[13] ^ m_h[12] ^ m_h[10];
      if (m_st == 0) begin
        m_h = {m_h[14:0], d};
        m_fill++;
        if (m_fill == 16) begin
          m_fill = 0;
          if (m_h != 16'd0) begin
            m_st = 1;
            m_match = 0;
          end
        end
      end else if (m_st == 1) begin
        m_h = {m_h[14:0], d};
        if (d == p) begin
          m_match++;
          if (m_match == LM) begin
            m_st = 2; m_wpos = 0; m_werr = 0;
          end
        end else begin
          m_st = 0; m_fill = 0; m_match = 0;
        end
      end else begin
        m_h = {m_h[14:0], p};
        e = (d != p);
        if (e) m_werr++;
        if (m_werr == EL) begin
          m_st = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
        end else if (m_wpos == WIN - 1) begin
          m_wpos = 0; m_werr = 0;
        end else begin
          m_wpos++;
        end
      end
    end
    if (c) begin
      m_cnt  = e ? 1 : 0;
      m_cnt4 = e ? 1 : 0;
    end else if (e) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    x.lk   = (m_st == 2);
    x.pl   = e;
    x.cnt  = 16'(m_cnt);
    x.cnt4 = 4'(m_cnt4);
    sb_q.push_back(x);
  endtask

  task automatic drive_raw(input logic d, input logic v, input logic c);
    exp_t e;
    @(negedge clk);
    din = d; din_valid = v; err_clr = c;
    model_step(d, v, c);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val("cycle", {8'd0, locked, err_pulse, locked4, err_pulse4, err_count, err_count4},
                {8'd0, e.lk, e.pl, e.lk, e.pl, e.cnt, e.cnt4});
    end
    pulses += int'(err_pulse);
  endtask

  // one generator bit (advanced only on valid cycles), optionally inverted
  task automatic drive(input logic flip, input logic v, input logic c);
    logic b;
    if (v) begin
      b = gen_r[15] ^ gen_r[13] ^ gen_r[12] ^ gen_r[10];
      gen_r = {gen_r[14:0], b};
      drive_raw(b ^ flip, 1'b1, c);
    end else begin
      drive_raw(1'($urandom_range(0, 1)), 1'b0, c);
    end
  endtask

  task automatic run_until_lock(input string tag, input logic gaps);
    int   nbits;
    logic v;
    nbits = 0;
    check_val({tag, "_pre"}, {31'd0, locked}, 32'd0);
    for (int i = 0; i < 200 && !locked; i++) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(1'b0, v, 1'b0);
      if (v) nbits++;
    end
    check_val({tag, "_bits"}, 32'(nbits), 32'd24);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0; din_valid = 1'b0; err_clr = 1'b0;
    #1;
    check_val({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check_val({tag, "_cnt"}, {16'd0, err_count}, 32'd0);
    check_val({tag, "_cnt4"}, {28'd0, err_count4}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    logic lk_seen;
    gen_r = 16'hFFFF;
    reset = 1'b0; din = 1'b0; din_valid = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_state", {29'd0, locked, err_pulse, locked4},      32'd0);
    check_val("rst_cnt",   {12'd0, err_count, err_count4},            32'd0);
    @(negedge clk);
    reset = 1'b1;

    // clean stream: lock after 24 bits, no errors over 1000 bits
    pulses = 0;
    run_until_lock("lock1", 1'b0);
    repeat (976) drive(1'b0, 1'b1, 1'b0);
    check_val("clean_pulses", 32'(pulses), 32'd0);
    check_val("clean_cnt", {16'd0, err_count}, 32'd0);
    check_val("clean_locked", {31'd0, locked}, 32'd1);

    // single flipped bit: one pulse, flywheel keeps lock
    pulses = 0;
    drive(1'b1, 1'b1, 1'b0);
    repeat (150) drive(1'b0, 1'b1, 1'b0);
    check_val("single_pulses", 32'(pulses), 32'd1);
    check_val("single_cnt", {16'd0, err_count}, 32'd1);
    check_val("single_locked", {31'd0, locked}, 32'd1);

    // four errors inside one window: loss of lock, then re-acquire
    for (int i = 0; i < WIN && m_wpos != 0; i++) drive(1'b0, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive((i % 3) == 0, 1'b1, 1'b0);
      if (i == 6) check_val("burst_hold", {31'd0, locked}, 32'd1);
    end
    check_val("burst_unlock", {31'd0, locked}, 32'd0);
    check_val("burst_cnt", {16'd0, err_count}, 32'd5);
    check_val("burst_pulses", 32'(pulses), 32'd4);
    run_until_lock("relock", 1'b0);

    // reset mid-LOCKED, then all-zero stream never locks
    apply_reset("rst_a");
    lk_seen = 1'b0;
    repeat (512) begin
      drive_raw(1'b0, 1'b1, 1'b0);
      lk_seen |= locked;
    end
    check_val("zero_nolock", {31'd0, lk_seen}, 32'd0);
    check_val("zero_cnt", {16'd0, err_count}, 32'd0);

    // gapped valid stream locks after 24 valid bits
    run_until_lock("gaps", 1'b1);

    // spaced single errors: 4-bit counter saturates, lock holds
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      repeat (70) drive(1'b0, 1'b1, 1'b0);
    end
    check_val("sat_cnt4", {28'd0, err_count4}, 32'd15);
    check_val("sat_cnt16", {16'd0, err_count}, 32'd20);
    check_val("sat_locked", {31'd0, locked}, 32'd1);
    drive(1'b1, 1'b1, 1'b1);
    check_val("clr_err_cnt", {16'd0, err_count}, 32'd1);
    check_val("clr_err_cnt4", {28'd0, err_count4}, 32'd1);
    drive(1'b0, 1'b1, 1'b1);
    check_val("clr_cnt", {16'd0, err_count}, 32'd0);
    check_val("clr_locked", {31'd0, locked}, 32'd1);
    repeat (70) drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);

    // async reset while locked, then while verifying
    check_val("pre_rst_cnt", {16'd0, err_count}, 32'd1);
    apply_reset("rst_lock");
    seen = 0;
    repeat (20) drive(1'b0, 1'b1, 1'b0);
    check_val("mid_verify", {31'd0, locked}, 32'd0);
    apply_reset("rst_ver");
    run_until_lock("lock_after_rst", 1'b0);
    repeat (10) drive(1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs16_checker.md
Name: prbs16_checker

Overview:
- Serial receiver/checker for the 16-bit PRBS stream produced by the team's LFSR generator.
- Polynomial is x^16+x^14+x^13+x^11+1: each bit b[n] = b[n-16]^b[n-14]^b[n-13]^b[n-11].
- Self-synchronises to the incoming bit stream, declares lock, then flags and counts bit errors.
- Drops lock when too many errors occur in a window. Sits at the far end of a link/loopback under test.

Parameters:
LOCK_MATCHES, 8, consecutive correct predictions needed after the 16-bit fill before lock is declared (1..255)
WINDOW, 64, valid-bit window length used for loss-of-lock detection (2..65535)
ERR_LIMIT, 4, errors within one window that force loss of lock (1..WINDOW)
CNT_W, 16, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
din  input  1  received serial PRBS bit
din_valid  input  1  din is sampled only when 1
err_clr  input  1  synchronous clear of err_count
locked  output  1  checker synchronised to the stream
err_pulse  output  1  one-cycle pulse, mismatch detected while locked
err_count  output  CNT_W  saturating count of errors seen while locked

Behaviour:
- Reset (reset=0, async): state=ACQUIRE, history h[15:0]=0, fill/match/window counters=0, locked=0, err_pulse=0, err_count=0.
- History: h[0] holds the newest bit. Prediction p = h[15]^h[13]^h[12]^h[10]. All updates happen only on cycles with din_valid=1.
- Cycles with din_valid=0: state, counters and history hold; err_pulse=0.
- ACQUIRE:
  - Each valid bit: h <= {h[14:0],din}, fill++.
  - On the 16th bit, go to VERIFY, unless the resulting h==0. In that case fill returns to 0 and the FSM stays in ACQUIRE; the all-zero stream never locks.
- VERIFY:
  - Each valid bit is compared with p, and din is shifted in.
  - On a match, match++. When match==LOCK_MATCHES, go to LOCKED and set locked=1 (registered, high the cycle after that bit is sampled).
  - On a mismatch, return to ACQUIRE with fill=0 and match=0.
- LOCKED:
  - The predicted bit p is shifted in (flywheel), not din, so an isolated error does not corrupt the history.
  - Mismatch: err_pulse=1 on the next cycle, err_count++ (saturates at 2^CNT_W-1), win_err++.
  - win_pos counts valid bits 0..WINDOW-1. At the wrap, win_pos=0 and win_err=0. An error on the last bit of a window counts toward that window before the clear.
  - If win_err reaches ERR_LIMIT: next state ACQUIRE, locked=0 on the next cycle, and fill/match/win counters=0. History is kept but refilled from scratch.
- err_count changes only in LOCKED; errors during VERIFY are not counted.
- err_clr: sets err_count=0. If an error is counted on the same cycle, err_count=1 (the error wins after the clear). err_clr has no effect on the FSM or locked.
- Latency: err_pulse and err_count update one clock after the offending bit is sampled.
- Assertion of reset mid-operation aborts immediately to the reset state. Release is synchronous to the next clk edge.

Optional Feature:
PRBS16_CHK_BITCNT_EN
- Defined: adds output bit_count [31:0], the number of valid bits sampled while locked.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by reset and by err_clr.
  - Reset value 0.
  - Together with err_count, it allows BER computation.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reference generator seeded 16'hFFFF drives din with din_valid=1 continuously, defaults -> locked=1 the cycle after valid bit 24 (16 fill + 8 matches), err_pulse never asserts, err_count=0 after 1000 bits.
- Locked; flip valid bit 100 only -> err_pulse high for exactly one cycle, err_count=1, locked stays 1, no further errors (flywheel holds).
- Locked; flip 4 bits inside one 64-bit window -> locked falls the cycle after the 4th error, err_count=4. Clean stream continues -> locked=1 again 24 valid bits later.
- din=0 constant for 500 valid bits -> locked never asserts, err_count=0. Toggle din_valid 50% with generator stream -> lock after 24 valid bits regardless of gaps.
- CNT_W=4, inject 20 single errors spaced >64 bits apart -> err_count saturates at 15, locked stays 1. Then assert err_clr on the same cycle as an error is counted -> err_count=1.
- Assert reset mid-VERIFY (bit 20) and mid-LOCKED -> locked=0, err_count=0 immediately (asynchronously). Re-acquire requires 24 fresh valid bits.
